// File: rtl/audio_dac_tx_if.sv
// Sample-pair handshake between the sample producer and the DAC transmitter FIFO.
interface audio_dac_tx_if #(
  parameter int unsigned SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] s_left;
  logic [SAMPLE_WIDTH-1:0] s_right;
  logic                    s_valid;
  logic                    s_ready;

  modport master (output s_left, output s_right, output s_valid, input s_ready);
  modport slave  (input s_left, input s_right, input s_valid, output s_ready);
endinterface

// File: rtl/audio_dac_tx.sv
// Stereo DAC transmitter for the Wolfson codec: BCLK/DACLRCK generation, sample-pair FIFO
// and MSB-first serialiser with left-justified or I2S framing and underrun tracking.
module audio_dac_tx #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SLOT_BITS    = 32,
  parameter int unsigned BCLK_HALF    = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned MODE         = 0
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  audio_dac_tx_if.slave               samples,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        AUD_BCLK,
  output logic                        AUD_DACLRCK,
  output logic                        AUD_DACDAT,
  output logic                        underrun,
  output logic [7:0]                  underrun_count
);
  localparam int unsigned DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned BIT_W      = $clog2(2 * SLOT_BITS);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W      = PTR_W + 1;
  localparam int unsigned FRAME_LAST = 2 * SLOT_BITS - 1;
  localparam logic [SAMPLE_WIDTH-1:0] MSB_MASK = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic [DIV_W-1:0]        divCnt;
  logic [BIT_W-1:0]        bitCnt;
  logic [PTR_W-1:0]        wrPtr;
  logic [PTR_W-1:0]        rdPtr;
  logic [SAMPLE_WIDTH-1:0] memL [FIFO_DEPTH];
  logic [SAMPLE_WIDTH-1:0] memR [FIFO_DEPTH];
  logic [SAMPLE_WIDTH-1:0] shadowL;
  logic [SAMPLE_WIDTH-1:0] shadowR;
  logic                    readyReg;

  logic                    divWrap;
  logic                    fallEdge;
  logic                    frameLoad;
  logic                    fifoEmpty;
  logic                    pushEn;
  logic                    popEn;
  logic                    rightSlot;
  logic                    dataOn;
  logic                    dataBit;
  logic [BIT_W-1:0]        nextBit;
  logic [BIT_W-1:0]        slotPos;
  logic [BIT_W:0]          k;
  logic [SAMPLE_WIDTH-1:0] loadL;
  logic [SAMPLE_WIDTH-1:0] loadR;
  logic [SAMPLE_WIDTH-1:0] activeSample;
  logic [LVL_W-1:0]        nextLevel;

  assign samples.s_ready = readyReg;

  // Edge detection, frame load and the bit that leaves on the next falling edge.
  always_comb begin
    divWrap      = 1'b0;
    fallEdge     = 1'b0;
    nextBit      = '0;
    frameLoad    = 1'b0;
    fifoEmpty    = 1'b0;
    loadL        = '0;
    loadR        = '0;
    rightSlot    = 1'b0;
    slotPos      = '0;
    activeSample = '0;
    k            = '0;
    dataOn       = 1'b0;
    dataBit      = 1'b0;
    pushEn       = 1'b0;
    popEn        = 1'b0;
    nextLevel    = fifo_level;

    divWrap   = (divCnt == DIV_W'(BCLK_HALF - 1));
    fallEdge  = divWrap && AUD_BCLK;
    nextBit   = (bitCnt == BIT_W'(FRAME_LAST)) ? '0 : bitCnt + BIT_W'(1);
    frameLoad = fallEdge && (nextBit == '0);
    fifoEmpty = (fifo_level == '0);
    if (!fifoEmpty) begin
      loadL = memL[rdPtr];
      loadR = memR[rdPtr];
    end

    // The left slot of a loading frame must already use the freshly popped sample.
    rightSlot    = (nextBit >= BIT_W'(SLOT_BITS));
    slotPos      = rightSlot ? nextBit - BIT_W'(SLOT_BITS) : nextBit;
    activeSample = rightSlot ? shadowR : (frameLoad ? loadL : shadowL);
    k            = {1'b0, slotPos} - (BIT_W + 1)'(MODE);
    dataOn       = !k[BIT_W] && (k[BIT_W-1:0] < BIT_W'(SAMPLE_WIDTH));
    dataBit      = dataOn && (|(activeSample & (MSB_MASK >> k[BIT_W-1:0])));

    pushEn    = samples.s_valid && readyReg;
    popEn     = frameLoad && !fifoEmpty;
    nextLevel = fifo_level + LVL_W'(pushEn) - LVL_W'(popEn);
  end

  // FIFO storage; stale entries are harmless because reset clears the pointers.
  always_ff @(posedge CLOCK_50) begin
    if (pushEn && !reset) begin
      memL[wrPtr] <= samples.s_left;
      memR[wrPtr] <= samples.s_right;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      divCnt         <= '0;
      bitCnt         <= BIT_W'(FRAME_LAST);
      AUD_BCLK       <= 1'b0;
      AUD_DACLRCK    <= 1'b0;
      AUD_DACDAT     <= 1'b0;
      shadowL        <= '0;
      shadowR        <= '0;
      wrPtr          <= '0;
      rdPtr          <= '0;
      fifo_level     <= '0;
      readyReg       <= 1'b1;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      divCnt <= divWrap ? '0 : divCnt + DIV_W'(1);
      if (divWrap) AUD_BCLK <= ~AUD_BCLK;

      if (fallEdge) begin
        bitCnt      <= nextBit;
        AUD_DACLRCK <= rightSlot;
        AUD_DACDAT  <= dataBit;
      end

      underrun <= frameLoad && fifoEmpty;
      if (frameLoad) begin
        shadowL <= loadL;
        shadowR <= loadR;
        if (fifoEmpty && (underrun_count != 8'hFF)) underrun_count <= underrun_count + 8'd1;
      end

      if (pushEn) wrPtr <= wrPtr + PTR_W'(1);
      if (popEn)  rdPtr <= rdPtr + PTR_W'(1);
      fifo_level <= nextLevel;
      readyReg   <= (nextLevel < LVL_W'(FIFO_DEPTH));
    end
  end
endmodule

// File: tb/tb_audio_dac_tx.sv
// Scoreboard bench: left-justified and I2S instances share stimulus; a timing/FIFO model
// predicts every output cycle by cycle.
module tb_audio_dac_tx;
  localparam int SW        = 16;
  localparam int SLOT      = 32;
  localparam int BH        = 2;
  localparam int DEPTH     = 4;
  localparam int FRAME_CYC = 4 * BH * SLOT;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    int            acc;
  } pair_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  audio_dac_tx_if #(.SAMPLE_WIDTH(SW)) bus0 ();
  audio_dac_tx_if #(.SAMPLE_WIDTH(SW)) bus1 ();

  logic [2:0] lvl0, lvl1;
  logic       bclk0, bclk1, lrck0, lrck1, dat0, dat1, und0, und1;
  logic [7:0] uc0, uc1;

  audio_dac_tx #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SLOT), .BCLK_HALF(BH), .FIFO_DEPTH(DEPTH), .MODE(0)) dut0 (
    .CLOCK_50(clk), .reset(reset), .samples(bus0.slave), .fifo_level(lvl0), .AUD_BCLK(bclk0),
    .AUD_DACLRCK(lrck0), .AUD_DACDAT(dat0), .underrun(und0), .underrun_count(uc0));

  audio_dac_tx #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SLOT), .BCLK_HALF(BH), .FIFO_DEPTH(DEPTH), .MODE(1)) dut1 (
    .CLOCK_50(clk), .reset(reset), .samples(bus1.slave), .fifo_level(lvl1), .AUD_BCLK(bclk1),
    .AUD_DACLRCK(lrck1), .AUD_DACDAT(dat1), .underrun(und1), .underrun_count(uc1));

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  logic  rstEdge = 1'b0;
  pair_t expQ[$];

  int          loads = 0;
  int          curBit = -1;
  logic [63:0] lastFrame0 = '0;
  logic [63:0] lastFrame1 = '0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rstEdge <= reset;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      if (errors >= 50) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  endtask

  function automatic logic expDat(input int mode, input logic [SW-1:0] s, input int pos);
    int k;
    k = pos - mode;
    if (k < 0 || k >= SW) return 1'b0;
    return s[SW-1-k];
  endfunction

  task automatic checkOne(input string tag, input logic bclk, input logic lrck, input logic dat,
                          input logic und, input logic [7:0] uc, input logic [2:0] lvl,
                          input logic rdy, input logic eBclk, input logic eLrck, input logic eDat,
                          input logic eUnd, input int eUc, input int eLvl);
    chk({tag, ".bclk"}, 64'(bclk), 64'(eBclk));
    chk({tag, ".lrck"}, 64'(lrck), 64'(eLrck));
    chk({tag, ".dat"}, 64'(dat), 64'(eDat));
    chk({tag, ".underrun"}, 64'(und), 64'(eUnd));
    chk({tag, ".underrun_count"}, 64'(uc), 64'(eUc));
    chk({tag, ".fifo_level"}, 64'(lvl), 64'(eLvl));
    chk({tag, ".s_ready"}, 64'(rdy), 64'(eLvl < DEPTH));
  endtask

  // Reference model: outputs follow from edges since reset release and the accepted-pair queue.
  initial begin : monitor
    int            tRel, f, lvl, pos, uCnt;
    logic          started, expUnder, fallNow, eL, e0, e1;
    logic [SW-1:0] frameL, frameR, smp;
    logic [63:0]   acc0, acc1;
    pair_t         keep[$];
    started = 1'b0; tRel = 0; uCnt = 0; expUnder = 1'b0;
    frameL = '0; frameR = '0; acc0 = '0; acc1 = '0;
    forever begin
      @(negedge clk);
      fallNow = 1'b0;
      if (rstEdge) begin
        started = 1'b1; tRel = 0; uCnt = 0; expUnder = 1'b0;
        frameL = '0; frameR = '0; acc0 = '0; acc1 = '0; curBit = -1;
        keep = {};
        foreach (expQ[i]) if (expQ[i].acc > cyc) keep.push_back(expQ[i]);
        expQ = keep;
      end else if (started) begin
        tRel++;
        expUnder = 1'b0;
        if (tRel % (2 * BH) == 0) begin
          fallNow = 1'b1;
          f = tRel / (2 * BH);
          curBit = (f - 1) % (2 * SLOT);
          if (curBit == 0) begin
            if (f > 1) begin
              lastFrame0 = acc0;
              lastFrame1 = acc1;
            end
            if (expQ.size() > 0 && expQ[0].acc < cyc) begin
              frameL = expQ[0].l;
              frameR = expQ[0].r;
              void'(expQ.pop_front());
            end else begin
              frameL = '0; frameR = '0; expUnder = 1'b1;
              if (uCnt < 255) uCnt++;
            end
            loads++;
          end
        end
      end
      if (started) begin
        lvl = 0;
        foreach (expQ[i]) if (expQ[i].acc <= cyc) lvl++;
        eL = 1'b0; e0 = 1'b0; e1 = 1'b0;
        if (curBit >= 0) begin
          eL  = (curBit >= SLOT);
          pos = curBit % SLOT;
          smp = eL ? frameR : frameL;
          e0  = expDat(0, smp, pos);
          e1  = expDat(1, smp, pos);
        end
        checkOne("lj", bclk0, lrck0, dat0, und0, uc0, lvl0, bus0.s_ready,
                 1'((tRel / BH) % 2), eL, e0, expUnder, uCnt, lvl);
        checkOne("i2s", bclk1, lrck1, dat1, und1, uc1, lvl1, bus1.s_ready,
                 1'((tRel / BH) % 2), eL, e1, expUnder, uCnt, lvl);
        if (fallNow) begin
          acc0 = {acc0[62:0], dat0};
          acc1 = {acc1[62:0], dat1};
        end
      end
    end
  end

  task automatic drive(input logic [SW-1:0] l, input logic [SW-1:0] r, input logic v);
    bus0.s_left = l; bus0.s_right = r; bus0.s_valid = v;
    bus1.s_left = l; bus1.s_right = r; bus1.s_valid = v;
  endtask

  // Called at a negedge; holds the pair until the handshake completes, records its accept edge.
  task automatic pushPair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int    waited;
    pair_t p;
    waited = 0;
    drive(l, r, 1'b1);
    while (bus0.s_ready !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 2 * FRAME_CYC) begin
        checks++; errors++;
        $display("FAIL push_timeout cycle %0d: s_ready still %0b, required 1", cyc, bus0.s_ready);
        drive(l, r, 1'b0);
        return;
      end
    end
    p.l = l; p.r = r; p.acc = cyc + 1;
    expQ.push_back(p);
    @(negedge clk);
    drive(l, r, 1'b0);
  endtask

  task automatic waitLoads(input int n);
    int target, w;
    target = loads + n;
    w = 0;
    while (loads < target) begin
      @(negedge clk);
      w++;
      if (w > (n + 2) * FRAME_CYC) begin
        checks++; errors++;
        $display("FAIL wait_loads cycle %0d: loads %0d, required %0d", cyc, loads, target);
        return;
      end
    end
    @(negedge clk);
  endtask

  initial begin : stimulus
    int w;
    drive('0, '0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Known pattern in both framings.
    pushPair(16'hA5C3, 16'h0F0F);
    waitLoads(2);
    chk("lj_frame", lastFrame0, 64'hA5C3_0000_0F0F_0000);
    chk("i2s_frame", lastFrame1, 64'h52E1_8000_0787_8000);

    // Fill the FIFO, then a fifth pair that waits for the next frame load.
    waitLoads(1);
    for (int i = 0; i < 4; i++) pushPair(16'($urandom()), 16'($urandom()));
    chk("full_level", 64'(lvl0), 64'd4);
    chk("full_ready", 64'(bus0.s_ready), 64'd0);
    pushPair(16'hFFFF, 16'h8001);
    waitLoads(5);

    // Randomised traffic with random gaps.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 150)) @(negedge clk);
      pushPair(16'($urandom()), 16'($urandom()));
    end

    // Let the FIFO drain, then several empty frames.
    w = 0;
    while (expQ.size() != 0 && w < 10 * FRAME_CYC) begin
      @(negedge clk);
      w++;
    end
    waitLoads(4);

    // Reset in the middle of a frame with two pairs queued.
    waitLoads(1);
    pushPair(16'h1234, 16'h5678);
    pushPair(16'h9ABC, 16'hDEF0);
    w = 0;
    while (curBit != 20 && w < 2 * FRAME_CYC) begin
      @(negedge clk);
      w++;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_level", 64'(lvl0), 64'd0);
    waitLoads(1);
    chk("rst_underrun_lj", 64'(uc0), 64'd1);
    chk("rst_underrun_i2s", 64'(uc1), 64'd1);

    // Saturation of the underrun counter.
    waitLoads(260);
    chk("sat_lj", 64'(uc0), 64'd255);
    chk("sat_i2s", 64'(uc1), 64'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
